// File: rtl/ram_pkg.sv
// Shared constants and FSM state encoding for the 64x16 RAM responder.
package ram_pkg;
  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 64;
  // clr_cnt carries one extra bit so the end of the fill never aliases to address 0
  localparam int CNT_W = AW + 1;

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_e;
endpackage

// File: rtl/ram64_responder_ram.sv
// RAM64_Optim: 64x16 storage, combinational read of address, write on the edge when load=1.
// Contents are not reset; the responder zero-fills them after every reset.
module RAM64_Optim
  import ram_pkg::*;
(
  input  logic [DW-1:0] in,
  input  logic          CLK,
  input  logic          load,
  input  logic [AW-1:0] address,
  output logic [DW-1:0] out
);
  logic [DW-1:0] mem_q [DEPTH];

  // single write port
  always_ff @(posedge CLK) begin
    if (load) mem_q[address] <= in;
  end

  assign out = mem_q[address];
endmodule

// File: rtl/ram64_responder.sv
// ram64_responder: valid/ready front end for RAM64_Optim. Zero-fills after reset, then
// serves posted writes and latency-1 reads with a single held response register.
module ram64_responder
  import ram_pkg::*;
(
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          init_done
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic             init_done_q, init_done_d;

  logic             accept;
  logic             ram_load;
  logic [AW-1:0]    ram_addr;
  logic [DW-1:0]    ram_in;
  logic [DW-1:0]    ram_out;

  // a held, undrained response blocks every request, writes included
  assign req_ready = (state_q == SERVE) & (~rsp_valid_q | rsp_ready);
  assign accept    = req_valid & req_ready;

  RAM64_Optim u_ram (
    .in      (ram_in),
    .CLK     (CLK),
    .load    (ram_load),
    .address (ram_addr),
    .out     (ram_out)
  );

  // next-state: fill sequencing in CLEAR, request/response bookkeeping in SERVE
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    init_done_d = init_done_q;
    ram_load    = 1'b0;
    ram_addr    = req_addr;
    ram_in      = req_wdata;
    case (state_q)
      CLEAR: begin
        ram_load  = 1'b1;
        ram_addr  = clr_cnt_q[AW-1:0];
        ram_in    = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d     = SERVE;
          init_done_d = 1'b1;
        end
      end
      SERVE: begin
        ram_load = accept & req_write;
        if (accept & ~req_write) begin
          // new read reloads the register even while the old one drains
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ram_out;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      init_done_q <= init_done_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = init_done_q;
endmodule

// File: tb/tb_ram64_responder.sv
// Scoreboard bench for ram64_responder: reads push the model's word at acceptance,
// responses are popped and compared when consumed.
module tb_ram64_responder;
  logic        CLK = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [5:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        init_done;

  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  logic [15:0] model [64];
  logic [15:0] sb [$];

  always #5 CLK = ~CLK;

  ram64_responder dut (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done)
  );

  // negedge: consume side of the scoreboard
  task automatic half_mon();
    logic [15:0] exp_d;
    @(negedge CLK);
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      checks++;
      pops++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: unexpected response data=%h", rsp_rdata);
      end else begin
        exp_d = sb.pop_front();
        if (rsp_rdata !== exp_d) begin
          errors++;
          $display("FAIL sb_data: got %h expected %h", rsp_rdata, exp_d);
        end
      end
    end
  endtask

  // one clock edge, leaving time at posedge+1
  task automatic tick();
    half_mon();
    @(posedge CLK);
    #1;
  endtask

  // present a request until accepted; waited = edges spent including the accepting one
  task automatic send(input logic w, input logic [5:0] a, input logic [15:0] d,
                      output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!acc && waited < 300) begin
      half_mon();
      acc = (req_ready === 1'b1);
      @(posedge CLK);
      #1;
      waited++;
    end
    req_valid = 1'b0;
    if (acc) begin
      if (w) model[a] = d;
      else   sb.push_back(model[a]);
    end else begin
      checks++; errors++;
      $display("FAIL send_timeout: addr=%0d never accepted", a);
    end
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int c = 0; c < 200 && sb.size() != 0; c++) tick();
    checks++;
    if (sb.size() != 0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: left=%0d rsp_valid=%b expected 0/0", sb.size(), rsp_valid);
    end
  endtask

  // release reset and return the number of edges until init_done rises
  task automatic wait_fill(output int n);
    n = 0;
    rst_n = 1'b1;
    while (init_done !== 1'b1 && n < 200) begin
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_clear: req_ready=%b expected 0 at cycle %0d", req_ready, n);
      end
      tick();
      n++;
    end
    for (int i = 0; i < 64; i++) model[i] = 16'h0;
  endtask

  task automatic test_reset();
    int n, w;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || init_done !== 1'b0 || rsp_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: v=%b rdy=%b done=%b data=%h expected 0/0/0/0000",
               rsp_valid, req_ready, init_done, rsp_rdata);
    end
    wait_fill(n);
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL fill_len: got %0d cycles expected 64", n);
    end
    send(1'b0, 6'd0, 16'h0, w);
    send(1'b0, 6'd31, 16'h0, w);
    send(1'b0, 6'd63, 16'h0, w);
    drain();
  endtask

  task automatic test_stream();
    int w, stalls, p0;
    stalls = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      send(1'b1, 6'(i), 16'(i * 3 + 1), w);
      stalls += w - 1;
    end
    p0 = pops;
    for (int i = 0; i < 64; i++) begin
      send(1'b0, 6'(i), 16'h0, w);
      stalls += w - 1;
    end
    drain();
    checks++;
    if (stalls != 0 || pops - p0 != 64) begin
      errors++;
      $display("FAIL stream: stalls=%0d responses=%0d expected 0/64", stalls, pops - p0);
    end
  endtask

  task automatic test_raw();
    int w;
    rsp_ready = 1'b1;
    send(1'b1, 6'd5, 16'hBEEF, w);
    send(1'b0, 6'd5, 16'h0, w);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL raw_latency: v=%b data=%h expected 1/beef", rsp_valid, rsp_rdata);
    end
    drain();
  endtask

  task automatic test_hold();
    int w;
    rsp_ready = 1'b1;
    send(1'b1, 6'd7, 16'h1234, w);
    rsp_ready = 1'b0;
    send(1'b0, 6'd7, 16'h0, w);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 6'd3; req_wdata = 16'hDEAD;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1234 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold: v=%b data=%h rdy=%b expected 1/1234/0", rsp_valid, rsp_rdata, req_ready);
      end
    end
    rsp_ready = 1'b1;
    send(1'b1, 6'd3, 16'hDEAD, w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL hold_release: waited %0d expected 1", w);
    end
    send(1'b0, 6'd3, 16'h0, w);
    send(1'b0, 6'd7, 16'h0, w);
    drain();
  endtask

  task automatic test_reset_mid();
    int n, w;
    rsp_ready = 1'b0;
    send(1'b0, 6'd7, 16'h0, w);
    rst_n = 1'b0;
    tick();
    sb.delete();
    checks++;
    if (rsp_valid !== 1'b0 || init_done !== 1'b0 || rsp_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_held: v=%b done=%b data=%h expected 0/0/0000", rsp_valid, init_done, rsp_rdata);
    end
    rst_n = 1'b1;
    repeat (20) tick();
    rst_n = 1'b0;
    tick();
    wait_fill(n);
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL refill_len: got %0d cycles expected 64", n);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 64; i++) send(1'b0, 6'(i), 16'h0, w);
    drain();
  endtask

  task automatic test_req_in_clear();
    int w;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) model[i] = 16'h0;
    rsp_ready = 1'b1;
    send(1'b1, 6'd9, 16'h5A5A, w);
    checks++;
    if (w != 65) begin
      errors++;
      $display("FAIL clear_accept: accepted after %0d edges expected 65", w);
    end
    send(1'b0, 6'd9, 16'h0, w);
    send(1'b0, 6'd8, 16'h0, w);
    drain();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_stream();
    test_raw();
    test_hold();
    test_reset_mid();
    test_req_in_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
